// File: rtl/bbw_halfdup_pkg.sv
// Shared types and width helpers for the half-duplex single-wire pad controller.
package bbw_halfdup_pkg;

    typedef enum logic [2:0] {IDLE, TX, TURN, RX, DONE} state_e;

    // Counter width that stays legal (>=1 bit) for degenerate parameter values.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_DW       = 8;
    localparam int DEF_BIT_CLKS = 4;
    localparam int DEF_TURN_CYC = 2;
    localparam int DEF_BW       = cw(DEF_DW);
    localparam int DEF_SW       = cw(DEF_BIT_CLKS);

endpackage

// File: rtl/bbw_halfdup_if.sv
// Request/response handshake plus pad I/T/O wires of one half-duplex bus pad.
interface bbw_halfdup_if #(
    parameter int DW = 8
);
    logic          REQ_VALID;
    logic          REQ_READY;
    logic [DW-1:0] REQ_DATA;
    logic          REQ_RD;
    logic          RSP_VALID;
    logic [DW-1:0] RSP_DATA;
    logic          BUSY;
    logic          PAD_I;
    logic          PAD_T;
    logic          PAD_O;

    modport master (
        output REQ_VALID, REQ_DATA, REQ_RD, PAD_O,
        input  REQ_READY, RSP_VALID, RSP_DATA, BUSY, PAD_I, PAD_T
    );

    modport slave (
        input  REQ_VALID, REQ_DATA, REQ_RD, PAD_O,
        output REQ_READY, RSP_VALID, RSP_DATA, BUSY, PAD_I, PAD_T
    );
endinterface

// File: rtl/bbw_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs; resets to 1 (idle wire level).
module bbw_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] ff_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff_q <= 2'b11;
        else        ff_q <= {ff_q[0], d_i};
    end

    assign q_o = ff_q[1];
endmodule

// File: rtl/bbw_halfdup_ctrl.sv
// Half-duplex single-wire controller: serialise a word, release for turnaround,
// optionally sample a response word mid-slot and hand it back as a one-cycle pulse.
module bbw_halfdup_ctrl
    import bbw_halfdup_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int BIT_CLKS = DEF_BIT_CLKS,
    parameter int TURN_CYC = DEF_TURN_CYC
) (
    input  logic          CLK,
    input  logic          RSTN,
    bbw_halfdup_if.slave  bus
);
    localparam int SW = cw(BIT_CLKS);
    localparam int BW = cw(DW);
    localparam int TW = cw(TURN_CYC);

    state_e          state_q, state_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [TW-1:0]   turn_q, turn_d;
    logic [DW-1:0]   tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
    logic            rd_q, rd_d;
    logic            pad_t_q, pad_t_d, pad_i_q, pad_i_d;
    logic            ready_q, ready_d, busy_q, busy_d, rsp_vld_q, rsp_vld_d;
    logic            rx_s;
    logic            slot_last, bit_last;

    bbw_sync2 u_sync (.clk(CLK), .rst_n(RSTN), .d_i(bus.PAD_O), .q_o(rx_s));

    // Reset is asynchronous so an aborted transfer releases the wire at once.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= IDLE;
            slot_q     <= '0;
            bit_q      <= '0;
            turn_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rd_q       <= 1'b0;
            rsp_data_q <= '0;
            pad_t_q    <= 1'b1;
            pad_i_q    <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            rsp_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            bit_q      <= bit_d;
            turn_q     <= turn_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rd_q       <= rd_d;
            rsp_data_q <= rsp_data_d;
            pad_t_q    <= pad_t_d;
            pad_i_q    <= pad_i_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            rsp_vld_q  <= rsp_vld_d;
        end
    end

    assign slot_last = (slot_q == SW'(BIT_CLKS - 1));
    assign bit_last  = (bit_q == '0);

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        bit_d   = bit_q;
        turn_d  = turn_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: if (bus.REQ_VALID && ready_q) begin
                state_d = TX;
                tx_d    = bus.REQ_DATA;
                rd_d    = bus.REQ_RD;
                bit_d   = BW'(DW - 1);
                slot_d  = '0;
            end
            TX: begin
                slot_d = slot_q + 1'b1;
                if (slot_last) begin
                    slot_d = '0;
                    tx_d   = {tx_q[DW-2:0], 1'b0};
                    bit_d  = bit_q - 1'b1;
                    if (bit_last) begin
                        state_d = TURN;
                        turn_d  = '0;
                    end
                end
            end
            TURN: begin
                turn_d = turn_q + 1'b1;
                if (turn_q == TW'(TURN_CYC - 1)) begin
                    state_d = rd_q ? RX : IDLE;
                    slot_d  = '0;
                    bit_d   = BW'(DW - 1);
                end
            end
            RX: begin
                slot_d = slot_q + 1'b1;
                // Mid-slot sampling leaves room for the synchroniser latency.
                if (slot_q == SW'(BIT_CLKS / 2)) rx_d = {rx_q[DW-2:0], rx_s};
                if (slot_last) begin
                    slot_d = '0;
                    bit_d  = bit_q - 1'b1;
                    if (bit_last) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state register.
    always_comb begin
        pad_t_d    = (state_d != TX);
        pad_i_d    = (state_d == TX) ? tx_d[DW-1] : 1'b1;
        ready_d    = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        rsp_vld_d  = (state_d == DONE);
        rsp_data_d = (state_d == DONE) ? rx_d : rsp_data_q;
    end

    assign bus.PAD_T     = pad_t_q;
    assign bus.PAD_I     = pad_i_q;
    assign bus.REQ_READY = ready_q;
    assign bus.BUSY      = busy_q;
    assign bus.RSP_VALID = rsp_vld_q;
    assign bus.RSP_DATA  = rsp_data_q;
endmodule
